// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and default constants shared by the uart frame path.
package uart_pkg;

  // Assembler states. CHECK is only entered when the checksum byte is enabled.
  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2
  } state_t;

  // Start-of-frame byte used unless the instance overrides it.
  localparam logic [7:0] DEFAULT_HEADER = 8'h80;

endpackage

// File: rtl/uart_frame_timer.sv
// uart_frame_timer: idle-cycle counter between bytes of a frame.
// expire is combinational: it is high in the cycle whose count would reach
// TIMEOUT_CYC, so the owner can act on the same clock edge. TIMEOUT_CYC == 0
// removes the counter entirely and expire is tied low.
module uart_frame_timer #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst_n, clr, en};
      assign expire        = 1'b0;
    end else begin : g_on
      localparam int TW = $clog2(TIMEOUT_CYC + 1);
      localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

      logic [TW-1:0] cnt_reg;

      // Count idle cycles; clear has priority so a byte restarts the window.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (clr) begin
          cnt_reg <= '0;
        end else if (en) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign expire = en & ~clr & (cnt_reg == LAST);
    end
  endgenerate

endmodule

// File: rtl/uart_frame_assembler.sv
// uart_frame_assembler: hunts for HEADER in the uart byte stream, collects
// WORD_BYTES payload bytes MSB-first and presents the word on a valid/ready
// register. Inter-byte timeout and rx_error abort the frame with a one-cycle
// frame_error pulse; a finished word that cannot be stored sets sticky overflow.
// Optional: define UART_FRAME_CSUM_EN to require a trailing checksum byte equal
// to HEADER XOR all payload bytes before the word is committed.
module uart_frame_assembler
  import uart_pkg::*;
#(
  parameter int         WORD_BYTES  = 2,
  parameter logic [7:0] HEADER      = DEFAULT_HEADER,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_byte,
  input  logic                    rx_error,
  output logic [8*WORD_BYTES-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    frame_error,
  output logic                    overflow,
  output logic                    busy
);

  localparam int W  = 8 * WORD_BYTES;
  localparam int CW = $clog2(WORD_BYTES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORD_BYTES - 1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic [W-1:0]    sh_reg;
  logic [W+7:0]    sh_cat;
  logic [W-1:0]    sh_shift;
  logic [7:0]      unused_sh_top;
  logic [W-1:0]    commit_word;
  logic [W-1:0]    dout_reg;
  logic            dout_valid_reg, frame_error_reg, overflow_reg;
  logic            start, take_byte, abort, commit_req, csum_bad;
  logic            tmr_clr, tmr_en, tmr_expire;

  // Shift in the new byte at the bottom; the oldest byte falls off the top.
  assign sh_cat        = {sh_reg, rx_byte};
  assign sh_shift      = sh_cat[W-1:0];
  assign unused_sh_top = sh_cat[W+7:W];

`ifdef UART_FRAME_CSUM_EN
  logic [7:0] csum_reg;
  // In CHECK the payload is already complete in the shift register.
  assign commit_word = sh_reg;
`else
  // Commit straight from the last payload byte, no extra register stage.
  assign commit_word = sh_shift;
`endif

  // The timer only runs inside a frame and restarts on every received byte.
  assign tmr_clr = (state_reg == HUNT) | rx_valid;
  assign tmr_en  = (state_reg != HUNT) & ~rx_valid;

  uart_frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= HUNT;
    else        state_reg <= state_next;
  end

  // Next state and per-cycle events; rx_error beats a simultaneous byte.
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    take_byte  = 1'b0;
    abort      = 1'b0;
    commit_req = 1'b0;
    csum_bad   = 1'b0;
    case (state_reg)
      HUNT: begin
        if (rx_valid && !rx_error && rx_byte == HEADER) begin
          start      = 1'b1;
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (rx_error || tmr_expire) begin
          abort      = 1'b1;
          state_next = HUNT;
        end else if (rx_valid) begin
          take_byte = 1'b1;
          if (cnt_reg == LAST_IDX) begin
`ifdef UART_FRAME_CSUM_EN
            state_next = CHECK;
`else
            commit_req = 1'b1;
            state_next = HUNT;
`endif
          end
        end
      end
`ifdef UART_FRAME_CSUM_EN
      CHECK: begin
        if (rx_error || tmr_expire) begin
          abort      = 1'b1;
          state_next = HUNT;
        end else if (rx_valid) begin
          state_next = HUNT;
          if (rx_byte == csum_reg) commit_req = 1'b1;
          else                     csum_bad   = 1'b1;
        end
      end
`endif
      default: state_next = HUNT;
    endcase
  end

  // Payload shift register and byte counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_reg  <= '0;
      cnt_reg <= '0;
    end else if (start) begin
      cnt_reg <= '0;
    end else if (take_byte) begin
      sh_reg  <= sh_shift;
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

`ifdef UART_FRAME_CSUM_EN
  // Running XOR seeded with the header byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         csum_reg <= '0;
    else if (start)     csum_reg <= HEADER;
    else if (take_byte) csum_reg <= csum_reg ^ rx_byte;
  end
`endif

  // Output word register: accept a finished word only if the slot is free
  // or being drained this cycle, otherwise drop it and flag overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else if (commit_req) begin
      if (!dout_valid_reg || dout_ready) begin
        dout_reg       <= commit_word;
        dout_valid_reg <= 1'b1;
      end else begin
        overflow_reg <= 1'b1;
      end
    end else if (dout_valid_reg && dout_ready) begin
      dout_valid_reg <= 1'b0;
    end
  end

  // One-cycle error pulse for timeout, rx_error abort or checksum mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_error_reg <= 1'b0;
    else        frame_error_reg <= abort | csum_bad;
  end

  assign dout        = dout_reg;
  assign dout_valid  = dout_valid_reg;
  assign frame_error = frame_error_reg;
  assign overflow    = overflow_reg;
  assign busy        = (state_reg != HUNT);

endmodule

// File: tb/tb_uart_frame_assembler.sv
// tb_uart_frame_assembler: table vectors, hand sequences for timing corners
// and a randomized stream checked against a queue-based frame model.
// Build with UART_FRAME_CSUM_EN defined to cover the checksum variant.
module tb_uart_frame_assembler;

  localparam logic [7:0] HDR = 8'h80;
  localparam int TO = 50;
`ifdef UART_FRAME_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0, rx_error = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        dout_ready = 1'b0, dout_ready4 = 1'b1;
  logic [15:0] dout;
  logic        dout_valid, frame_error, overflow, busy;
  logic [31:0] dout4;
  logic        dout_valid4, frame_error4, overflow4, busy4;

  int n_err = 0;
  int n_chk = 0;

  uart_frame_assembler #(.WORD_BYTES(2), .HEADER(HDR), .TIMEOUT_CYC(TO)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_error(rx_error),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .frame_error(frame_error), .overflow(overflow), .busy(busy));

  uart_frame_assembler #(.WORD_BYTES(4), .HEADER(HDR), .TIMEOUT_CYC(0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_error(rx_error),
    .dout(dout4), .dout_valid(dout_valid4), .dout_ready(dout_ready4),
    .frame_error(frame_error4), .overflow(overflow4), .busy(busy4));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          m_in_frame;
  logic [7:0]  m_bytes[$];
  int          m_idle;
  logic [15:0] e_dout;
  bit          e_valid, e_ferr, e_ovf, e_busy;

  function automatic void model_reset();
    m_in_frame = 0; m_bytes.delete(); m_idle = 0;
    e_dout = '0; e_valid = 0; e_ferr = 0; e_ovf = 0; e_busy = 0;
  endfunction

  // Predicts outputs after the clock edge that samples these inputs.
  task automatic model_step(input bit v, input logic [7:0] b, input bit e, input bit rdy);
    bit commit, ferr;
    logic [15:0] word;
    logic [7:0] x;
    commit = 0; ferr = 0; word = '0;
    if (!m_in_frame) begin
      if (v && !e && b == HDR) begin
        m_in_frame = 1; m_bytes.delete(); m_idle = 0;
      end
    end else if (e) begin
      ferr = 1; m_in_frame = 0;
    end else if (v) begin
      m_bytes.push_back(b); m_idle = 0;
      if (m_bytes.size() == 2 + CS) begin
        m_in_frame = 0;
        word = {m_bytes[0], m_bytes[1]};
        x = HDR ^ m_bytes[0] ^ m_bytes[1];
        if (CS == 0 || x == m_bytes[m_bytes.size()-1]) commit = 1;
        else ferr = 1;
      end
    end else begin
      m_idle++;
      if (m_idle == TO) begin ferr = 1; m_in_frame = 0; end
    end
    if (commit && (!e_valid || rdy)) begin
      e_dout = word; e_valid = 1;
      $display("txn commit word=%h", word);
    end else if (commit) begin
      e_ovf = 1;
      $display("txn dropped word=%h", word);
    end else if (e_valid && rdy) begin
      e_valid = 0;
    end
    e_ferr = ferr; e_busy = m_in_frame;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [7:0] b, input bit e, input bit rdy);
    rx_valid = v; rx_byte = b; rx_error = e; dout_ready = rdy;
    @(posedge clk); #1;
    rx_valid = 0; rx_error = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".dout"},        64'(dout),        64'(e_dout));
    chk({tag, ".dout_valid"},  64'(dout_valid),  64'(e_valid));
    chk({tag, ".frame_error"}, 64'(frame_error), 64'(e_ferr));
    chk({tag, ".overflow"},    64'(overflow),    64'(e_ovf));
    chk({tag, ".busy"},        64'(busy),        64'(e_busy));
  endtask

  task automatic step(input bit v, input logic [7:0] b, input bit e, input bit rdy);
    model_step(v, b, e, rdy);
    drive(v, b, e, rdy);
    check_model("model");
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input bit rdy_last);
    step(1, HDR, 0, 0);
    step(1, b0, 0, 0);
    if (CS != 0) begin
      step(1, b1, 0, 0);
      step(1, HDR ^ b0 ^ b1, 0, rdy_last);
    end else begin
      step(1, b1, 0, rdy_last);
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          v;
    logic [7:0]  b;
    bit          rdy;
    bit          x_valid;
    logic [15:0] x_dout;
    bit          x_ferr;
    bit          x_ovf;
    bit          x_busy;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int gap;
    // Fill table: {v, byte, ready, exp valid, exp dout, exp ferr, exp ovf, exp busy}
`ifdef UART_FRAME_CSUM_EN
    tbl.push_back('{1, 8'h80, 1, 0, 16'h0000, 0, 0, 1});
    tbl.push_back('{1, 8'h12, 1, 0, 16'h0000, 0, 0, 1});
    tbl.push_back('{1, 8'h34, 1, 0, 16'h0000, 0, 0, 1});
    tbl.push_back('{1, 8'hA6, 1, 1, 16'h1234, 0, 0, 0});
    tbl.push_back('{0, 8'h00, 1, 0, 16'h1234, 0, 0, 0});
    tbl.push_back('{1, 8'h80, 0, 0, 16'h1234, 0, 0, 1});
    tbl.push_back('{1, 8'h12, 0, 0, 16'h1234, 0, 0, 1});
    tbl.push_back('{1, 8'h34, 0, 0, 16'h1234, 0, 0, 1});
    tbl.push_back('{1, 8'h00, 0, 0, 16'h1234, 1, 0, 0});
    tbl.push_back('{0, 8'h00, 0, 0, 16'h1234, 0, 0, 0});
`else
    tbl.push_back('{1, 8'h80, 1, 0, 16'h0000, 0, 0, 1});
    tbl.push_back('{1, 8'h12, 1, 0, 16'h0000, 0, 0, 1});
    tbl.push_back('{1, 8'h34, 1, 1, 16'h1234, 0, 0, 0});
    tbl.push_back('{0, 8'h00, 1, 0, 16'h1234, 0, 0, 0});
    tbl.push_back('{0, 8'h00, 0, 0, 16'h1234, 0, 0, 0});
    tbl.push_back('{1, 8'h80, 0, 0, 16'h1234, 0, 0, 1});
    tbl.push_back('{1, 8'hAA, 0, 0, 16'h1234, 0, 0, 1});
    tbl.push_back('{1, 8'hBB, 0, 1, 16'hAABB, 0, 0, 0});
    tbl.push_back('{0, 8'h00, 0, 1, 16'hAABB, 0, 0, 0});
    tbl.push_back('{1, 8'h80, 0, 1, 16'hAABB, 0, 0, 1});
    tbl.push_back('{1, 8'hCC, 0, 1, 16'hAABB, 0, 0, 1});
    tbl.push_back('{1, 8'hDD, 0, 1, 16'hAABB, 0, 1, 0});
    tbl.push_back('{0, 8'h00, 1, 0, 16'hAABB, 0, 1, 0});
`endif

    // Power-on reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset.dout", 64'(dout), 64'h0);
    chk("reset.dout_valid", 64'(dout_valid), 64'h0);
    chk("reset.frame_error", 64'(frame_error), 64'h0);
    chk("reset.overflow", 64'(overflow), 64'h0);
    chk("reset.busy", 64'(busy), 64'h0);
    rst_n = 1;
    model_reset();

    // Table vectors.
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].b, 0, tbl[i].rdy);
      $display("txn vec %0d byte=%h valid=%0b dout=%h", i, tbl[i].b, dout_valid, dout);
      chk($sformatf("vec%0d.dout_valid", i), 64'(dout_valid), 64'(tbl[i].x_valid));
      chk($sformatf("vec%0d.dout", i), 64'(dout), 64'(tbl[i].x_dout));
      chk($sformatf("vec%0d.frame_error", i), 64'(frame_error), 64'(tbl[i].x_ferr));
      chk($sformatf("vec%0d.overflow", i), 64'(overflow), 64'(tbl[i].x_ovf));
      chk($sformatf("vec%0d.busy", i), 64'(busy), 64'(tbl[i].x_busy));
    end

    // Commit coinciding with the handshake replaces the word, no overflow.
    do_reset();
    send_frame(8'hAA, 8'hBB, 0);
    send_frame(8'hCC, 8'hDD, 1);
    chk("ovf_hs.dout", 64'(dout), 64'h0000CCDD);
    chk("ovf_hs.overflow", 64'(overflow), 64'h0);
    chk("ovf_hs.dout_valid", 64'(dout_valid), 64'h1);

    // Timeout after exactly TO idle cycles, then a clean frame.
    do_reset();
    step(1, HDR, 0, 1);
    step(1, 8'h12, 0, 1);
    for (int k = 0; k < TO; k++) step(0, 8'h00, 0, 1);
    chk("timeout.frame_error", 64'(frame_error), 64'h1);
    chk("timeout.busy", 64'(busy), 64'h0);
    step(0, 8'h00, 0, 1);
    send_frame(8'h56, 8'h78, 1);
    chk("after_to.dout", 64'(dout), 64'h00005678);

    // A byte arriving in the would-expire cycle keeps the frame alive.
    step(1, HDR, 0, 1);
    step(1, 8'h12, 0, 1);
    for (int k = 0; k < TO - 1; k++) step(0, 8'h00, 0, 1);
    step(1, 8'h34, 0, 1);
    chk("to_edge.frame_error", 64'(frame_error), 64'h0);
    if (CS != 0) step(1, HDR ^ 8'h12 ^ 8'h34, 0, 1);
    chk("to_edge.dout", 64'(dout), 64'h00001234);

    // rx_error mid-frame aborts without touching dout.
    step(1, HDR, 0, 1);
    step(1, 8'hEE, 0, 1);
    step(1, 8'h55, 1, 1);
    chk("rxerr.frame_error", 64'(frame_error), 64'h1);
    chk("rxerr.busy", 64'(busy), 64'h0);
    chk("rxerr.dout", 64'(dout), 64'h00001234);

    // Asynchronous reset mid-frame with a pending word.
    send_frame(8'hAB, 8'hCD, 0);
    step(1, HDR, 0, 0);
    step(1, 8'h12, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("arst.dout", 64'(dout), 64'h0);
    chk("arst.dout_valid", 64'(dout_valid), 64'h0);
    chk("arst.overflow", 64'(overflow), 64'h0);
    chk("arst.frame_error", 64'(frame_error), 64'h0);
    chk("arst.busy", 64'(busy), 64'h0);
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();

    // Four-byte instance: leading junk ignored, header value inside payload is data.
    dout_ready4 = 0;
    drive(1, 8'h55, 0, 0);
    drive(1, 8'h80, 0, 0);
    drive(1, 8'hDE, 0, 0);
    drive(1, 8'hAD, 0, 0);
    drive(1, 8'h80, 0, 0);
    drive(1, 8'hEF, 0, 0);
    if (CS != 0) drive(1, 8'h9C, 0, 0);
    $display("txn wide dout=%h valid=%0b", dout4, dout_valid4);
    chk("wide.dout", 64'(dout4), 64'hDEAD80EF);
    chk("wide.dout_valid", 64'(dout_valid4), 64'h1);
    repeat (3) drive(0, 8'h00, 0, 0);
    chk("wide.hold_dout", 64'(dout4), 64'hDEAD80EF);
    chk("wide.hold_valid", 64'(dout_valid4), 64'h1);
    dout_ready4 = 1;
    drive(0, 8'h00, 0, 0);
    chk("wide.drained", 64'(dout_valid4), 64'h0);
    do_reset();

    // Randomized stream against the model.
    gap = 0;
    for (int i = 0; i < 3000; i++) begin
      bit v, e, rdy;
      logic [7:0] b;
      if (gap > 0) begin
        gap--;
        v = 0;
      end else begin
        v = ($urandom_range(0, 99) < 45);
        if ($urandom_range(0, 99) < 3) gap = $urandom_range(40, 60);
      end
      b = ($urandom_range(0, 3) == 0) ? HDR : 8'($urandom);
      e = ($urandom_range(0, 99) < 2);
      rdy = ($urandom_range(0, 99) < 50);
      step(v, b, e, rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_frame_assembler.md
Name: uart_frame_assembler

Overview:
- Parametrised successor to the fixed two-byte header/high/low word loader that sits behind a uart receiver.
- Consumes the uart byte strobe (received/rx_byte) synchronously in the clk domain. Hunts for a header byte, then assembles WORD_BYTES payload bytes MSB-first into one word.
- Presents the word on a valid/ready output register. Adds an inter-byte timeout, receive-error abort, overflow detection and an optional checksum.

Parameters:
- WORD_BYTES, 2: payload bytes per frame, 1..8; dout width = 8*WORD_BYTES.
- HEADER, 8'h80: start-of-frame byte.
- TIMEOUT_CYC, 100000: max clk cycles between bytes inside a frame; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle strobe, rx_byte valid (uart received).
- rx_byte  in  8  received byte.
- rx_error  in  1  one-cycle uart framing error strobe.
- dout  out  8*WORD_BYTES  assembled word, first byte in MSBs.
- dout_valid  out  1  dout holds an unconsumed word.
- dout_ready  in  1  consumer accepts dout when dout_valid & dout_ready.
- frame_error  out  1  one-cycle pulse: timeout, rx_error abort or checksum fail.
- overflow  out  1  sticky; a completed frame was dropped; cleared by reset only.
- busy  out  1  high while the FSM is not in HUNT.

Behaviour:
- Reset (async assert, sync release): state HUNT, dout=0, dout_valid=0, frame_error=0, overflow=0, busy=0, byte counter=0, timer=0.
- FSM states: HUNT, COLLECT, CHECK (CHECK exists only with FRAME_CSUM_EN).
- HUNT:
  - rx_valid & rx_byte==HEADER -> COLLECT, counter=0, timer=0.
  - Any other byte is ignored.
- COLLECT:
  - Each rx_valid shifts rx_byte into the shift register (sh = {sh[..-8], rx_byte}), counter+1, timer=0.
  - A byte equal to HEADER inside COLLECT is data; there is no escaping.
  - On the WORD_BYTES-th byte: go to HUNT, or to CHECK if the feature is enabled.
- Word commit (registered): dout and dout_valid update on the clk edge after the strobe of the last byte (the checksum byte if enabled). Latency is 1 cycle.
- Commit rules:
  - Commit when dout_valid==0, or dout_valid & dout_ready in that same cycle: dout=sh, dout_valid=1.
  - dout_valid & !dout_ready: the frame is dropped, dout is unchanged, overflow<=1, no frame_error.
- Handshake:
  - dout_valid falls the cycle after dout_valid & dout_ready unless a commit coincides.
  - dout must be stable while dout_valid & !dout_ready.
- Timeout:
  - The timer increments each cycle in COLLECT/CHECK without rx_valid.
  - Reaching TIMEOUT_CYC -> HUNT, frame_error pulse, partial data discarded.
  - An rx_valid in the cycle the timer would expire wins: the byte is accepted and the timer is cleared.
- rx_error in COLLECT/CHECK -> HUNT, frame_error pulse. rx_error in HUNT is ignored. rx_error together with rx_valid: the error wins.
- busy = (state != HUNT).
- Reset mid-frame: all state is cleared immediately, and a pending dout is lost.
- Timer width = $clog2(TIMEOUT_CYC+1); counter width = $clog2(WORD_BYTES+1).

Optional Feature:
- Macro: UART_FRAME_CSUM_EN.
- Defined:
  - One extra byte follows the payload; it must equal XOR of HEADER and all payload bytes (running XOR register).
  - CHECK takes that byte. On match, commit per the rules above. On mismatch, frame_error pulse, no commit, HUNT.
  - Timeout and rx_error apply in CHECK.
- Undefined: CHECK, the XOR register and the compare are absent; commit follows the last payload byte.

Decomposition:
- Shared package uart_pkg: state encoding (HUNT/COLLECT/CHECK localparams), default HEADER constant 8'h80.
- One natural sub-module, uart_frame_timer: loadable idle-cycle counter with clear, enable and expire outputs, parametrised by TIMEOUT_CYC. Tied off when TIMEOUT_CYC==0.

Test Plan:
- WORD_BYTES=2, bytes 80,12,34, dout_ready=1 -> dout=16'h1234, dout_valid high 1 cycle after the 34 strobe, then low after the handshake.
- WORD_BYTES=4, bytes 55,80,DE,AD,80,EF, dout_ready=0 -> 55 ignored, dout=32'hDEAD80EF held with dout_valid=1 until ready.
- Frame 80,AA,BB held unread, then 80,CC,DD with dout_ready=0 -> dout stays 16'hAABB, overflow=1. Repeat with dout_ready=1 in the commit cycle -> dout=16'hCCDD, overflow stays 0.
- TIMEOUT_CYC=50, bytes 80,12 then idle 50 cycles -> frame_error pulse, busy=0. Next 80,56,78 -> dout=16'h5678.
- rx_error after 80,12 -> frame_error pulse, HUNT, no dout change. rst_n low mid-frame -> all outputs 0 asynchronously.
- UART_FRAME_CSUM_EN: 80,12,34,A6 -> dout=16'h1234. 80,12,34,00 -> frame_error, no commit.
